conv3x3_window_mac: RTL and testbench
=====================================

// Module: conv3x3_window_mac
// PURPOSE
//  Downstream consumer of the stride-2 3x3 line buffer: takes one 9-tap window per valid cycle,
//  multiplies each tap by a stored signed weight, adds a bias and returns one fixed-point result.
//  Weights and bias load serially before the frame; the datapath is fully pipelined, so it
//  accepts one window per clock. Results go to the next layer's line buffer or the output writer.
// PARAMETERS
//  data_width  16  signed width of taps, weights, bias and result (Q format, two's complement)
//  frac_bits   8   fractional bits in taps/weights/bias; product scaled back by this amount
// PORTS
//  clk           in   1           rising-edge clock, the only clock
//  rst           in   1           asynchronous, active-low reset
//  weight_load   in   1           pulse: start a new coefficient load (restarts if one is in progress)
//  weight_valid  in   1           weight_in is valid this cycle
//  weight_in     in   data_width  coefficient stream: w0..w8, then bias (10 words)
//  weights_ready out  1           1 = coefficient set complete, windows accepted
//  window_valid  in   1           taps valid (driven by line buffer output_valid)
//  win_0..win_8  in   data_width  window taps, win_0 oldest row/col .. win_8 newest
//  result_valid  out  1           result valid, exactly 4 cycles after the accepted window
//  result        out  data_width  saturated, rescaled convolution result
//  drop_err      out  1           sticky: window_valid seen while weights_ready=0
// BEHAVIOUR
//  Reset (rst=0, async): FSM->EMPTY, coeff regs=0, all pipeline valids=0, result=0,
//   result_valid=0, weights_ready=0, drop_err=0.
//  FSM EMPTY -> (weight_load) -> LOADING, cnt=0
//      LOADING: each weight_valid stores weight_in at index cnt, cnt++; after cnt=9 (bias) -> READY
//      READY  -> (weight_load) -> LOADING, cnt=0 (weights_ready drops the next cycle)
//      weight_load in LOADING restarts at cnt=0; weight_load and weight_valid together: word taken as w0.
//      weight_valid outside LOADING ignored.
//  Coefficients are double-buffered: shadow set written in LOADING, copied to active set on
//   the LOADING->READY edge; in-flight windows always finish with the set they entered with.
//  Accept: window_valid && weights_ready. window_valid && !weights_ready -> window dropped,
//   drop_err=1 until reset.
//  Pipeline (valid bit per stage, no backpressure):
//   S1 products p_i = win_i * w_i, signed 2*data_width
//   S2 three partial sums of 3 products, width 2*data_width+2
//   S3 total = sum of partials + (bias <<< frac_bits), width 2*data_width+4
//   S4 total >>> frac_bits (arithmetic, truncate toward -inf), saturate to
//      [-2^(data_width-1), 2^(data_width-1)-1]; register to result
//  result keeps its last value when result_valid=0.
//  Back-to-back windows give back-to-back results, in order, with no bubbles.
// CONFIGURATION
//  CONV3X3_RELU_EN defined: S4 forces negative saturated values to 0 (fused ReLU); latency unchanged.
//  Not defined: signed result passed through unchanged.
// STRUCTURE
//  Shared package: data_width/frac_bits defaults, FSM state encodings (EMPTY/LOADING/READY),
//   COEFF_COUNT=10, PIPE_LATENCY=4, saturation min/max constants.
//  Sub-module: conv3x3_coeff_loader (FSM, counter, shadow/active coefficient registers);
//   the top holds the S1-S4 datapath.
// TESTING
//  1 Load w=all 0x0100 (1.0), bias 0; window all 0x0100 -> result 0x0900, result_valid 4 cycles later.
//  2 Window 0x7FFF all taps, weights 0x7FFF -> result 0x7FFF (positive saturation);
//    taps 0x8000, weights 0x7FFF -> 0x8000 (with CONV3X3_RELU_EN: 0x0000).
//  3 window_valid before any load -> no result_valid, drop_err=1 and stays 1.
//  4 10 back-to-back windows with ramp taps 1..10 (Q8) -> 10 consecutive valid results, in order,
//    matching reference model.
//  5 Reload (weights x2) while 3 windows in flight -> those 3 use the old weights; windows after
//    weights_ready=1 use the new ones.
//  6 rst=0 mid-stream -> result_valid=0 and weights_ready=0 immediately (async);
//    after release no result until a new load completes.

Source files
------------

// File: rtl/conv3x3_window_mac_pkg.sv
// Shared widths, coefficient-loader state encoding and saturation bounds for the 3x3 window MAC.
package conv3x3_window_mac_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int FRAC_BITS    = 8;
  localparam int TAP_COUNT    = 9;
  localparam int COEFF_COUNT  = 10;
  localparam int PIPE_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } coeff_state_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(DATA_WIDTH);
  localparam longint SAT_MIN = sat_min(DATA_WIDTH);

endpackage

// File: rtl/conv3x3_coeff_loader.sv
// Serial coefficient loader: w0..w8 then bias into a shadow set, committed to the active set
// when the bias lands, so windows already in the datapath keep the set they entered with.
module conv3x3_coeff_loader
  import conv3x3_window_mac_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 weight_load_i,
  input  logic                 weight_valid_i,
  input  logic [DW-1:0]        weight_in_i,
  output logic                 weights_ready_o,
  output logic signed [DW-1:0] coeff_o [COEFF_COUNT]
);

  localparam int CW = $clog2(COEFF_COUNT);

  coeff_state_e         state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        wr_idx;
  logic                 wr_en;
  logic                 commit;
  logic signed [DW-1:0] shadow_q [COEFF_COUNT];
  logic signed [DW-1:0] active_q [COEFF_COUNT];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    commit  = 1'b0;
    if (weight_load_i) begin
      // A word arriving with the load pulse is w0 of the new set.
      state_d = ST_LOADING;
      cnt_d   = '0;
      if (weight_valid_i) begin
        wr_en  = 1'b1;
        wr_idx = '0;
        cnt_d  = CW'(1);
      end
    end else if (state_q == ST_LOADING && weight_valid_i) begin
      wr_en = 1'b1;
      if (cnt_q == CW'(COEFF_COUNT - 1)) begin
        state_d = ST_READY;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      for (int i = 0; i < COEFF_COUNT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_en) shadow_q[wr_idx] <= weight_in_i;
      if (commit) begin
        // The bias is still on the input this cycle, not yet in the shadow set.
        for (int i = 0; i < COEFF_COUNT - 1; i++) active_q[i] <= shadow_q[i];
        active_q[COEFF_COUNT-1] <= weight_in_i;
      end
    end
  end

  assign weights_ready_o = (state_q == ST_READY);
  assign coeff_o         = active_q;

endmodule

// File: rtl/conv3x3_window_mac.sv
// 3x3 window MAC: 4-cycle pipeline, one window per clock, no backpressure (unready windows dropped, drop_err_o sticky).
// CONV3X3_RELU_EN: clamp negative saturated results to zero in the final stage.
module conv3x3_window_mac
  import conv3x3_window_mac_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int FB = FRAC_BITS
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          weight_load_i,
  input  logic          weight_valid_i,
  input  logic [DW-1:0] weight_in_i,
  output logic          weights_ready_o,
  input  logic          window_valid_i,
  input  logic [DW-1:0] win_0_i,
  input  logic [DW-1:0] win_1_i,
  input  logic [DW-1:0] win_2_i,
  input  logic [DW-1:0] win_3_i,
  input  logic [DW-1:0] win_4_i,
  input  logic [DW-1:0] win_5_i,
  input  logic [DW-1:0] win_6_i,
  input  logic [DW-1:0] win_7_i,
  input  logic [DW-1:0] win_8_i,
  output logic          result_valid_o,
  output logic [DW-1:0] result_o,
  output logic          drop_err_o
);

  localparam int PW = 2 * DW;
  localparam int SW = PW + 2;
  localparam int AW = PW + 4;
  localparam logic signed [AW-1:0] SAT_HI = AW'(sat_max(DW));
  localparam logic signed [AW-1:0] SAT_LO = AW'(sat_min(DW));

  logic signed [DW-1:0] tap   [TAP_COUNT];
  logic signed [DW-1:0] coeff [COEFF_COUNT];
  logic                 accept;

  logic [PIPE_LATENCY-1:0] vld_q;
  logic signed [PW-1:0]    prod_q [TAP_COUNT];
  logic signed [SW-1:0]    psum_q [3];
  logic signed [AW-1:0]    total_q;
  logic signed [DW-1:0]    bias1_q, bias2_q;
  logic signed [AW-1:0]    shifted;
  logic [DW-1:0]           result_d, result_q;
  logic                    drop_q;

  conv3x3_coeff_loader #(.DW(DW)) u_loader (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .weight_load_i  (weight_load_i),
    .weight_valid_i (weight_valid_i),
    .weight_in_i    (weight_in_i),
    .weights_ready_o(weights_ready_o),
    .coeff_o        (coeff)
  );

  assign tap[0] = win_0_i;
  assign tap[1] = win_1_i;
  assign tap[2] = win_2_i;
  assign tap[3] = win_3_i;
  assign tap[4] = win_4_i;
  assign tap[5] = win_5_i;
  assign tap[6] = win_6_i;
  assign tap[7] = win_7_i;
  assign tap[8] = win_8_i;

  assign accept = window_valid_i && weights_ready_o;

  always_comb begin
    shifted  = total_q >>> FB;
    result_d = shifted[DW-1:0];
    if (shifted > SAT_HI)      result_d = SAT_HI[DW-1:0];
    else if (shifted < SAT_LO) result_d = SAT_LO[DW-1:0];
`ifdef CONV3X3_RELU_EN
    if (result_d[DW-1]) result_d = '0;
`endif
  end

  // Bias travels with its window so a commit mid-flight cannot mix coefficient sets.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q    <= '0;
      for (int i = 0; i < TAP_COUNT; i++) prod_q[i] <= '0;
      for (int j = 0; j < 3; j++) psum_q[j] <= '0;
      total_q  <= '0;
      bias1_q  <= '0;
      bias2_q  <= '0;
      result_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      vld_q  <= {vld_q[PIPE_LATENCY-2:0], accept};
      drop_q <= drop_q | (window_valid_i & ~weights_ready_o);
      if (accept) begin
        for (int i = 0; i < TAP_COUNT; i++) prod_q[i] <= PW'(tap[i]) * PW'(coeff[i]);
        bias1_q <= coeff[COEFF_COUNT-1];
      end
      if (vld_q[0]) begin
        for (int j = 0; j < 3; j++)
          psum_q[j] <= SW'(prod_q[3*j]) + SW'(prod_q[3*j+1]) + SW'(prod_q[3*j+2]);
        bias2_q <= bias1_q;
      end
      if (vld_q[1])
        total_q <= AW'(psum_q[0]) + AW'(psum_q[1]) + AW'(psum_q[2]) + (AW'(bias2_q) <<< FB);
      if (vld_q[2]) result_q <= result_d;
    end
  end

  assign result_valid_o = vld_q[PIPE_LATENCY-1];
  assign result_o       = result_q;
  assign drop_err_o     = drop_q;

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Directed bench for conv3x3_window_mac: arithmetic reference model plus per-cycle output compare.
module tb_conv3x3_window_mac;
  import conv3x3_window_mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        weight_load, weight_valid, window_valid;
  logic [15:0] weight_in;
  logic [15:0] win [9];
  logic        weights_ready, result_valid, drop_err;
  logic [15:0] result;

  always #5 clk = ~clk;

  conv3x3_window_mac dut (
    .clk_i(clk), .rst_ni(rst_n),
    .weight_load_i(weight_load), .weight_valid_i(weight_valid), .weight_in_i(weight_in),
    .weights_ready_o(weights_ready), .window_valid_i(window_valid),
    .win_0_i(win[0]), .win_1_i(win[1]), .win_2_i(win[2]), .win_3_i(win[3]), .win_4_i(win[4]),
    .win_5_i(win[5]), .win_6_i(win[6]), .win_7_i(win[7]), .win_8_i(win[8]),
    .result_valid_o(result_valid), .result_o(result), .drop_err_o(drop_err)
  );

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        e_q[$];
  int          m_w[10];
  bit          m_ready = 1'b0;
  bit          m_drop  = 1'b0;
  logic [15:0] last_res = 16'h0;
  int          t[9];
  int          w[10];

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endfunction

  // Straight fixed-point arithmetic: sum of products plus scaled bias, floor-rescale, clamp.
  function automatic logic [15:0] model(input int tp[9], input int wt[10]);
    longint acc = 0;
    for (int i = 0; i < 9; i++) acc += longint'(tp[i]) * longint'(wt[i]);
    acc += longint'(wt[9]) * 256;
    acc = acc >>> 8;
    if (acc > SAT_MAX) acc = SAT_MAX;
    if (acc < SAT_MIN) acc = SAT_MIN;
`ifdef CONV3X3_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return 16'(acc);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      while (e_q.size() > 0 && e_q[0].due < cyc) begin
        check("missed_result", 32'(result_valid), 32'(1));
        void'(e_q.pop_front());
      end
      if (e_q.size() > 0 && e_q[0].due == cyc) begin
        check("result_valid", 32'(result_valid), 32'(1));
        check("result", 32'(result), 32'(e_q[0].val));
        last_res = e_q[0].val;
        void'(e_q.pop_front());
      end else begin
        check("result_valid_idle", 32'(result_valid), 32'(0));
        check("result_hold", 32'(result), 32'(last_res));
      end
      check("weights_ready", 32'(weights_ready), 32'(m_ready));
      check("drop_err", 32'(drop_err), 32'(m_drop));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_window(input int tp[9]);
    exp_t e;
    for (int i = 0; i < 9; i++) win[i] = 16'(tp[i]);
    window_valid = 1'b1;
    if (m_ready) begin
      e.due = cyc + 4;
      e.val = model(tp, m_w);
      e_q.push_back(e);
    end
    @(posedge clk);
    #1;
    window_valid = 1'b0;
    if (!m_ready) m_drop = 1'b1;
  endtask

  task automatic load(input int wt[10]);
    weight_load = 1'b1;
    @(posedge clk);
    #1;
    weight_load = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      weight_valid = 1'b1;
      weight_in    = 16'(wt[i]);
      @(posedge clk);
      #1;
    end
    weight_valid = 1'b0;
    m_ready = 1'b1;
    m_w = wt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    weight_load = 1'b0; weight_valid = 1'b0; window_valid = 1'b0; weight_in = 16'h0;
    for (int i = 0; i < 9; i++) win[i] = 16'h0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_result_valid", 32'(result_valid), 32'(0));
    check("rst_weights_ready", 32'(weights_ready), 32'(0));
    check("rst_drop_err", 32'(drop_err), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    idle(2);
    rst_n = 1'b1;

    // Window before any coefficient load is dropped and latches drop_err.
    for (int i = 0; i < 9; i++) t[i] = 256;
    drive_window(t);
    idle(6);

    // Unity weights: nine taps of 1.0 sum to 9.0, four cycles after the window.
    for (int i = 0; i < 9; i++) w[i] = 256;
    w[9] = 0;
    load(w);
    drive_window(t);
    idle(3);
    @(negedge clk);
    check("t1_literal_valid", 32'(result_valid), 32'(1));
    check("t1_literal_result", 32'(result), 32'h0900);
    idle(1);

    // Saturation at both rails.
    for (int i = 0; i < 9; i++) w[i] = 32767;
    w[9] = 0;
    load(w);
    for (int i = 0; i < 9; i++) t[i] = 32767;
    drive_window(t);
    for (int i = 0; i < 9; i++) t[i] = -32768;
    drive_window(t);
    idle(2);
    @(negedge clk);
    check("t2_pos_sat", 32'(result), 32'h7FFF);
    @(negedge clk);
`ifdef CONV3X3_RELU_EN
    check("t2_neg_sat", 32'(result), 32'h0000);
`else
    check("t2_neg_sat", 32'(result), 32'h8000);
`endif
    idle(2);

    // Ten back-to-back ramp windows with mixed-sign weights and a 0.5 bias.
    w = '{256, -128, 64, 512, 0, -256, 32, 128, 384, 128};
    load(w);
    for (int n = 1; n <= 10; n++) begin
      for (int i = 0; i < 9; i++) t[i] = n * 256 + i * 16 - 1024;
      drive_window(t);
    end
    idle(6);

    // Reload with doubled set while three windows are still in the pipeline.
    for (int n = 11; n <= 13; n++) begin
      for (int i = 0; i < 9; i++) t[i] = n * 64 - i * 32;
      drive_window(t);
    end
    for (int i = 0; i < 10; i++) w[i] = w[i] * 2;
    load(w);
    for (int n = 14; n <= 16; n++) begin
      for (int i = 0; i < 9; i++) t[i] = n * 64 - i * 32;
      drive_window(t);
    end
    idle(6);

    // Asynchronous reset mid-stream.
    drive_window(t);
    drive_window(t);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_result_valid", 32'(result_valid), 32'(0));
    check("t6_async_weights_ready", 32'(weights_ready), 32'(0));
    e_q.delete();
    m_ready  = 1'b0;
    m_drop   = 1'b0;
    last_res = 16'h0;
    idle(2);
    rst_n = 1'b1;
    drive_window(t);
    idle(6);
    w = '{256, -128, 64, 512, 0, -256, 32, 128, 384, 128};
    load(w);
    drive_window(t);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
